// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, state encoding and flag layout
// for the FPU datapath blocks.
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int Q_BITS = 26;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // flags = {invalid, div_zero, overflow, underflow}
    localparam int F_INVALID   = 3;
    localparam int F_DIV_ZERO  = 2;
    localparam int F_OVERFLOW  = 1;
    localparam int F_UNDERFLOW = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIVIDE,
        S_ROUND,
        S_DONE
    } state_t;
endpackage

// File: rtl/fp_unpack_classify.sv
// Combinational field split and class detection for one single-precision operand.
// Denormals are flushed: any zero exponent field reads as zero.
module fp_unpack_classify
    import fp_pkg::*;
(
    input  logic [31:0]      x,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] man,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan
);
    assign sign    = x[31];
    assign exp     = x[30:23];
    assign man     = x[22:0];
    assign is_zero = (exp == '0);
    assign is_inf  = (exp == '1) && (man == '0);
    assign is_nan  = (exp == '1) && (man != '0);
endmodule

// File: rtl/fp_div_seq.sv
// Iterative single-precision divider: radix-2 restoring mantissa divide,
// one quotient bit per cycle, round-to-nearest-even, start/busy/done handshake.
module fp_div_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [3:0]  flags
);
    state_t             state;
    logic [31:0]        a_r, b_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [24:0]        rem;
    logic [23:0]        dvs;
    logic [Q_BITS-1:0]  q;
    logic [4:0]         cnt;

    logic             sa, sb, za, zb, ia, ib, na, nb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;

    fp_unpack_classify u_ua (
        .x(a_r), .sign(sa), .exp(ea), .man(ma),
        .is_zero(za), .is_inf(ia), .is_nan(na)
    );
    fp_unpack_classify u_ub (
        .x(b_r), .sign(sb), .exp(eb), .man(mb),
        .is_zero(zb), .is_inf(ib), .is_nan(nb)
    );

    logic        res_sign;
    logic        spec;
    logic [31:0] spec_q;
    logic [3:0]  spec_f;

    assign res_sign = sa ^ sb;

    // Special-case priority: first matching branch wins.
    always_comb begin
        spec   = 1'b1;
        spec_q = '0;
        spec_f = '0;
        if (na || nb) begin
            spec_q            = QNAN;
            spec_f[F_INVALID] = 1'b1;
        end else if ((ia && ib) || (za && zb)) begin
            spec_q            = QNAN;
            spec_f[F_INVALID] = 1'b1;
        end else if (ia) begin
            spec_q = {res_sign, POS_INF[30:0]};
        end else if (zb) begin
            spec_q             = {res_sign, POS_INF[30:0]};
            spec_f[F_DIV_ZERO] = 1'b1;
        end else if (za || ib) begin
            spec_q = {res_sign, 31'b0};
        end else begin
            spec = 1'b0;
        end
    end

    logic        rem_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    assign rem_ge   = (rem >= {1'b0, dvs});
    assign rem_sub  = rem_ge ? (rem - {1'b0, dvs}) : rem;
    assign rem_next = {rem_sub[23:0], 1'b0};

    logic [23:0]       mant;
    logic              guard, sticky, round_up;
    logic [24:0]       mant_r;
    logic [23:0]       mant_f;
    logic signed [9:0] exp_n, exp_f;
    logic [31:0]       round_q;
    logic [3:0]        round_f;

    // exp_r holds ea-eb+126; a quotient MSB of 1 means one more binade.
    always_comb begin
        round_q = '0;
        round_f = '0;
        if (q[25]) begin
            mant   = q[25:2];
            guard  = q[1];
            sticky = q[0] | (|rem);
            exp_n  = exp_r + 10'sd1;
        end else begin
            mant   = q[24:1];
            guard  = q[0];
            sticky = |rem;
            exp_n  = exp_r;
        end
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {24'b0, round_up};
        if (mant_r[24]) begin
            mant_f = mant_r[24:1];
            exp_f  = exp_n + 10'sd1;
        end else begin
            mant_f = mant_r[23:0];
            exp_f  = exp_n;
        end
        if (exp_f >= 10'sd255) begin
            round_q             = {sign_r, POS_INF[30:0]};
            round_f[F_OVERFLOW] = 1'b1;
        end else if (exp_f <= 10'sd0) begin
            round_q              = {sign_r, 31'b0};
            round_f[F_UNDERFLOW] = 1'b1;
        end else begin
            round_q = {sign_r, exp_f[7:0], mant_f[22:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            quot   <= '0;
            flags  <= '0;
            a_r    <= '0;
            b_r    <= '0;
            sign_r <= 1'b0;
            exp_r  <= '0;
            rem    <= '0;
            dvs    <= '0;
            q      <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        busy  <= 1'b1;
                        flags <= '0;
                        state <= S_CHECK;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    sign_r <= res_sign;
                    if (spec) begin
                        quot  <= spec_q;
                        flags <= spec_f;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rem   <= {2'b01, ma};
                        dvs   <= {1'b1, mb};
                        q     <= '0;
                        cnt   <= '0;
                        exp_r <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
                        state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem <= rem_next;
                    q   <= {q[Q_BITS-2:0], rem_ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(Q_BITS - 1))
                        state <= S_ROUND;
                end
                S_ROUND: begin
                    quot  <= round_q;
                    flags <= round_f;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// Randomised and directed bench for fp_div_seq against an integer-arithmetic
// reference divider with round-to-nearest-even.
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] quot;
    logic [3:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    fp_div_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quot(quot), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: mantissa quotient as an exact integer ratio, rounded by
    // comparing the discarded part against one half.
    task automatic model(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [3:0] fl, output int lat);
        int   ex, ey, e, w;
        logic s, zx, zy, ix, iy, nx, ny;
        longint na, nb, num, qq, rm, keep, lost, half;
        bit   up;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        zx = (ex == 0); zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0); iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0); ny = (ey == 255) && (y[22:0] != 0);
        s  = x[31] ^ y[31];
        fl = 4'b0000; lat = 2;
        if (nx || ny)                   begin r = 32'h7FC00000; fl = 4'b1000; end
        else if ((ix && iy) || (zx && zy)) begin r = 32'h7FC00000; fl = 4'b1000; end
        else if (ix)                    r = {s, 31'h7F800000};
        else if (zy)                    begin r = {s, 31'h7F800000}; fl = 4'b0100; end
        else if (zx || iy)              r = {s, 31'h0};
        else begin
            lat = 29;
            na  = longint'(x[22:0]) + 64'd8388608;
            nb  = longint'(y[22:0]) + 64'd8388608;
            num = na * 64'd33554432;
            qq  = num / nb;
            rm  = num % nb;
            e   = ex - ey + 127;
            if (qq >= 64'd33554432) w = 2;
            else begin w = 1; e = e - 1; end
            keep = qq >> w;
            lost = qq - (keep << w);
            half = 64'd1 << (w - 1);
            up   = (lost > half) || (lost == half && (rm != 0 || keep[0]));
            if (up) keep = keep + 1;
            if (keep == 64'd16777216) begin keep = keep >> 1; e = e + 1; end
            if (e >= 255)     begin r = {s, 31'h7F800000}; fl = 4'b0010; end
            else if (e <= 0)  begin r = {s, 31'h0};        fl = 4'b0001; end
            else              r = {s, 8'(e), keep[22:0]};
        end
    endtask

    function automatic logic [31:0] rand_fp();
        int          k;
        logic        s;
        logic [22:0] m;
        k = int'($urandom_range(0, 13));
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case (k)
            0:       return {s, 8'h00, m};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 8'hFF, m | 23'h1};
            3:       return {s, 8'(int'($urandom_range(1, 6))), m};
            4:       return {s, 8'(int'($urandom_range(248, 254))), m};
            5:       return {s, 8'd127, 23'h0};
            default: return {s, 8'(int'($urandom_range(1, 254))), m};
        endcase
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 100) begin
            @(posedge clk); lat++; #1;
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag,
                          output logic [31:0] rq, output logic [3:0] rf);
        logic [31:0] eq;
        logic [3:0]  ef;
        int          elat, lat;
        model(x, y, eq, ef, elat);
        issue(x, y);
        lat = 1;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({tag, ".lat"}, 32'(lat), 32'(elat));
        chk({tag, ".quot"}, quot, eq);
        chk({tag, ".flags"}, 32'(flags), 32'(ef));
        rq = quot; rf = flags;
    endtask

    initial begin
        logic [31:0] rq, eq;
        logic [3:0]  rf, ef;
        int          lat, elat;
        bit          seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.quot", quot, 32'd0);
        chk("rst.flags", 32'(flags), 32'd0);
        rst = 1'b0;

        run_op(32'h40800000, 32'h40000000, "4div2", rq, rf);
        chk("4div2.lit", rq, 32'h40000000);
        run_op(32'h3F800000, 32'h40400000, "1div3", rq, rf);
        chk("1div3.lit", rq, 32'h3EAAAAAB);
        run_op(32'h3F800000, 32'h00000000, "1div0", rq, rf);
        chk("1div0.lit", {rq[31:0]}, 32'h7F800000);
        chk("1div0.flit", 32'(rf), 32'h4);
        run_op(32'h00000000, 32'h00000000, "0div0", rq, rf);
        chk("0div0.lit", rq, 32'h7FC00000);
        chk("0div0.flit", 32'(rf), 32'h8);
        run_op(32'h7F7FFFFF, 32'h3F000000, "ovf", rq, rf);
        chk("ovf.lit", rq, 32'h7F800000);
        chk("ovf.flit", 32'(rf), 32'h2);
        run_op(32'h00800000, 32'h40000000, "unf", rq, rf);
        chk("unf.lit", rq, 32'h00000000);
        chk("unf.flit", 32'(rf), 32'h1);

        // Start pulse in the middle of an operation must be ignored.
        issue(32'h40800000, 32'h40000000);
        lat = 1;
        repeat (3) begin @(posedge clk); lat++; end
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); lat++; #1;
        start = 1'b0;
        chk("ign.busy", 32'(busy), 32'd1);
        wait_done(lat);
        chk("ign.lat", 32'(lat), 32'd29);
        chk("ign.quot", quot, 32'h40000000);

        // New start in the DONE cycle is taken immediately.
        a = 32'h41100000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.done", 32'(done), 32'd0);
        lat = 1;
        wait_done(lat);
        chk("b2b.lat", 32'(lat), 32'd29);
        chk("b2b.quot", quot, 32'h40400000);

        // Reset while dividing aborts without a done pulse.
        issue(32'h3F800000, 32'h40400000);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.quot", quot, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        chk("arst.nodone", 32'(seen), 32'd0);
        run_op(32'h40C00000, 32'hBFC00000, "post", rq, rf);
        chk("post.lit", rq, 32'hC0800000);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] x, y;
            x = rand_fp();
            y = rand_fp();
            model(x, y, eq, ef, elat);
            run_op(x, y, $sformatf("rnd%0d", i), rq, rf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
